aes_encryptor: RTL and testbench

Iterative AES-128 encryption core that computes one round per clock and is the forward-direction counterpart of the AES decryptor in the PF_AES design. Round keys are not expanded internally. The core drives a 4-bit round index on `SelKey`, and the surrounding logic (a key-schedule ROM or table) returns the matching 128-bit round key combinationally on `Key`. The state uses the same row-major byte layout as the rest of PF_AES, so the encryptor and decryptor share one key table.

---
 rtl/aes_encryptor.sv | 146 ++++++++++++++
 tb/tb_aes_encryptor.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encryptor.sv
// aes_encryptor: iterative AES-128 encryption core, one round per clock.
// Round keys come from an external table indexed by SelKey and return
// combinationally on Key. The state is kept row-major: s(r,c) sits at
// bits [127-8*(4r+c) -: 8], matching the PF_AES decryptor.
// Optional build macro: AES_ENC_ABORT_EN (En low during ROUND aborts).
module aes_encryptor (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         En,
  input  logic [127:0] Key,
  input  logic [127:0] PT,
  output logic [3:0]   SelKey,
  output logic         Ry,
  output logic [127:0] CT
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_e        state_q, state_d;
  logic [3:0]    rnd_q, rnd_d;
  logic [127:0]  st_q, st_d;
  logic [127:0]  ct_q, ct_d;
  logic          ry_q, ry_d;
  logic [127:0]  sr_w, mc_w;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = SBOX[s[8*i +: 8]];
    return r;
  endfunction

  // Row r rotates left by r bytes: out(r,c) = in(r,(c+r) mod 4).
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int row = 0; row < 4; row++)
      for (int c = 0; c < 4; c++)
        r[127-8*(4*row+c) -: 8] = s[127-8*(4*row+((c+row)%4)) -: 8];
    return r;
  endfunction

  // Column c is spread across the four rows at byte offsets c, 4+c, 8+c, 12+c.
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-8*c      -: 8];
      a1 = s[127-8*(4+c)  -: 8];
      a2 = s[127-8*(8+c)  -: 8];
      a3 = s[127-8*(12+c) -: 8];
      r[127-8*c      -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[127-8*(4+c)  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[127-8*(8+c)  -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[127-8*(12+c) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  assign sr_w = shift_rows(sub_bytes(st_q));
  assign mc_w = mix_columns(sr_w);

  // Next-state logic: round sequencing, datapath update and ready flag.
  always_comb begin
    // NOTE: every target gets a hold value first so no path leaves it unassigned (no latches).
    state_d = state_q;
    rnd_d   = rnd_q;
    st_d    = st_q;
    ct_d    = ct_q;
    ry_d    = ry_q;
    case (state_q)
      IDLE: begin
        if (En) begin
          st_d    = PT ^ Key;
          rnd_d   = 4'd1;
          state_d = ROUND;
        end
      end
      ROUND: begin
`ifdef AES_ENC_ABORT_EN
        if (!En) begin
          rnd_d   = 4'd0;
          state_d = IDLE;
        end else
`endif
        if (rnd_q == 4'd10) begin
          ct_d    = sr_w ^ Key;
          ry_d    = 1'b1;
          rnd_d   = 4'd0;
          state_d = DONE;
        end else begin
          st_d  = mc_w ^ Key;
          rnd_d = rnd_q + 4'd1;
        end
      end
      DONE: begin
        if (!En) begin
          ry_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        rnd_d   = 4'd0;
        ry_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset, including the datapath state.
  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (Rst) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      st_q    <= '0;
      ct_q    <= '0;
      ry_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
      ct_q    <= ct_d;
      ry_q    <= ry_d;
    end
  end

  // The round index doubles as the key-table index: 0 outside ROUND.
  assign SelKey = rnd_q;
  assign Ry     = ry_q;
  assign CT     = ct_q;

endmodule

// File: tb/tb_aes_encryptor.sv
// tb_aes_encryptor: self-checking bench for aes_encryptor. A byte-level
// FIPS-197 reference model (S-box derived from GF(2^8) inverses) supplies
// the key table and expected ciphertexts.
module tb_aes_encryptor;

  logic         Clk = 1'b0;
  logic         Rst, En;
  logic [127:0] Key, PT, CT;
  logic [3:0]   SelKey;
  logic         Ry;

  logic [127:0] key_tbl [16];
  logic [7:0]   sbox_tb [256];
  int           n_cmp = 0;
  int           n_bad = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b28ab097eaef7cf15d2154f16a6883c;
  localparam logic [127:0] FIPS_PT  = 128'h328831e0435a3137f6309807a88da234;
  localparam logic [127:0] FIPS_CT  = 128'h3902dc1925dc116a8409850b1dfb9732;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  aes_encryptor dut (
    .Clk(Clk), .Rst(Rst), .En(En), .Key(Key), .PT(PT),
    .SelKey(SelKey), .Ry(Ry), .CT(CT)
  );

  always #5 Clk = ~Clk;

  always_comb Key = key_tbl[SelKey];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return gmul_ret(p);
  endfunction

  function automatic logic [7:0] gmul_ret(input logic [7:0] p);
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // Row-major <-> FIPS column-major byte order (the mapping is its own inverse).
  function automatic logic [127:0] transpose(input logic [127:0] x);
    logic [127:0] y;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        y[127-8*(4*r+c) -: 8] = x[127-8*(4*c+r) -: 8];
    return y;
  endfunction

  // Round key n of a FIPS-ordered cipher key, via the standard word expansion.
  function automatic logic [127:0] round_key(input logic [127:0] k, input int n);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tb[t[31:24]], sbox_tb[t[23:16]], sbox_tb[t[15:8]], sbox_tb[t[7:0]]};
        t = t ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endfunction

  function automatic logic [7:0] mcoef(input int d);
    case (d)
      0:       return 8'h02;
      1:       return 8'h03;
      default: return 8'h01;
    endcase
  endfunction

  // Reference encryption on row-major key/plaintext, returning row-major CT.
  function automatic logic [127:0] ref_encrypt(input logic [127:0] key_rm, input logic [127:0] pt_rm);
    logic [127:0] ks, s;
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   m [16];
    ks = transpose(key_rm);
    s  = transpose(pt_rm) ^ round_key(ks, 0);
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) b[i] = sbox_tb[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = b[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          if (rd < 10) begin
            m[4*c+r] = 8'h00;
            for (int k = 0; k < 4; k++) m[4*c+r] = m[4*c+r] ^ gmul(mcoef((k - r + 4) % 4), t[4*c+k]);
          end else begin
            m[4*c+r] = t[4*c+r];
          end
        end
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = m[i];
      s = s ^ round_key(ks, rd);
    end
    return transpose(s);
  endfunction

  task automatic load_key(input logic [127:0] key_rm);
    for (int n = 0; n < 11; n++) key_tbl[n] = transpose(round_key(transpose(key_rm), n));
  endtask

  // Starts an operation and waits (bounded) for Ry; lat counts edges after the start edge.
  task automatic run_op(input logic [127:0] pt, output int lat);
    PT = pt;
    En = 1'b1;
    tick();
    lat = 0;
    while (!Ry && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    vec_t         vecs [6];
    int           lat;
    logic [127:0] rnd_pt, exp_ct, prev_ct;
    logic         ry_seen;

    for (int i = 0; i < 16; i++) key_tbl[i] = '0;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    vecs[0] = '{FIPS_KEY, FIPS_PT, FIPS_CT};
    for (int i = 1; i < 6; i++) begin
      vecs[i].key = {$urandom(), $urandom(), $urandom(), $urandom()};
      vecs[i].pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      vecs[i].ct  = ref_encrypt(vecs[i].key, vecs[i].pt);
    end

    // Reset state, with En high to show reset wins.
    Rst = 1'b1; En = 1'b1; PT = FIPS_PT;
    tick(); tick();
    check("rst_selkey", 128'(SelKey), 128'd0);
    check("rst_ry", 128'(Ry), 128'd0);
    check("rst_ct", CT, 128'd0);
    Rst = 1'b0; En = 1'b0;
    tick();

    // Table-driven vectors.
    for (int i = 0; i < 6; i++) begin
      load_key(vecs[i].key);
      run_op(vecs[i].pt, lat);
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'd10);
      check($sformatf("vec%0d_ct", i), CT, vecs[i].ct);
      En = 1'b0;
      tick();
      check($sformatf("vec%0d_ry_clear", i), 128'(Ry), 128'd0);
      check($sformatf("vec%0d_ct_hold", i), CT, vecs[i].ct);
    end

    // SelKey sequence, then Ry handshake with En held high.
    load_key(FIPS_KEY);
    check("seq_selkey_idle", 128'(SelKey), 128'd0);
    PT = FIPS_PT; En = 1'b1;
    tick();
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("seq_selkey_%0d", k), 128'(SelKey), 128'(k));
      check($sformatf("seq_ry_low_%0d", k), 128'(Ry), 128'd0);
      tick();
    end
    check("seq_selkey_done", 128'(SelKey), 128'd0);
    check("seq_ry_done", 128'(Ry), 128'd1);
    check("seq_ct", CT, FIPS_CT);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("hold_ry_%0d", k), 128'(Ry), 128'd1);
      check($sformatf("hold_selkey_%0d", k), 128'(SelKey), 128'd0);
    end
    En = 1'b0;
    tick();
    check("hs_ry_clear", 128'(Ry), 128'd0);
    rnd_pt = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_op(rnd_pt, lat);
    check("hs_rerun_latency", 128'(lat), 128'd10);
    check("hs_rerun_ct", CT, ref_encrypt(FIPS_KEY, rnd_pt));
    En = 1'b0;
    tick();

    // PT changes after the start edge have no effect.
    PT = FIPS_PT; En = 1'b1;
    tick();
    PT = '0;
    lat = 0;
    while (!Ry && lat < 20) begin
      tick();
      lat++;
    end
    check("ptchg_latency", 128'(lat), 128'd10);
    check("ptchg_ct", CT, FIPS_CT);
    En = 1'b0;
    tick();

    // Reset during round 5 with En held high.
    PT = {$urandom(), $urandom(), $urandom(), $urandom()}; En = 1'b1;
    tick();
    repeat (4) tick();
    check("rst5_selkey_before", 128'(SelKey), 128'd5);
    Rst = 1'b1;
    tick();
    check("rst5_selkey", 128'(SelKey), 128'd0);
    check("rst5_ry", 128'(Ry), 128'd0);
    check("rst5_ct", CT, 128'd0);
    Rst = 1'b0; En = 1'b0;
    tick();
    check("rst5_idle", 128'(SelKey), 128'd0);
    run_op(FIPS_PT, lat);
    check("rst5_rerun_latency", 128'(lat), 128'd10);
    check("rst5_rerun_ct", CT, FIPS_CT);
    En = 1'b0;
    tick();

    // En dropped at round 4.
    prev_ct = CT;
    rnd_pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
    exp_ct  = ref_encrypt(FIPS_KEY, rnd_pt);
    PT = rnd_pt; En = 1'b1;
    tick();
    repeat (3) tick();
    check("abort_selkey_before", 128'(SelKey), 128'd4);
    En = 1'b0;
    tick();
`ifdef AES_ENC_ABORT_EN
    check("abort_selkey", 128'(SelKey), 128'd0);
    ry_seen = Ry;
    for (int k = 0; k < 12; k++) begin
      tick();
      ry_seen = ry_seen | Ry;
    end
    check("abort_ry_never", 128'(ry_seen), 128'd0);
    check("abort_ct_kept", CT, prev_ct);
`else
    check("noabort_running", 128'(SelKey), 128'd5);
    ry_seen = Ry;
    lat = 0;
    while (!ry_seen && lat < 20) begin
      tick();
      lat++;
      ry_seen = Ry;
    end
    check("noabort_ry", 128'(ry_seen), 128'd1);
    check("noabort_ct", CT, exp_ct);
    tick();
    check("noabort_ry_clear", 128'(Ry), 128'd0);
    check("noabort_ct_changed", 128'(CT == prev_ct), 128'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
